chunked_adder: RTL

Parametrised multi-cycle adder/subtractor that computes a WIDTH-bit sum CHUNK bits per clock, with the carry held in a register between chunks. It is the sequential, wide-operand successor to the single-bit full adder cell. It sits in arithmetic datapaths where a full-width single-cycle carry chain does not meet timing. A start/done handshake lets a controller issue back-to-back operations.

---
 rtl/chunked_adder_if.sv | 26 ++
 rtl/chunked_adder.sv | 115 +++++++++++
 2 files changed

// File: rtl/chunked_adder_if.sv
// Handshake and operand bus for chunked_adder. The controller drives the
// master modport and the adder implements the slave modport.
interface chunked_adder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB chunk first,
// with the carry held in a register. Signed overflow is available under CHUNKED_ADDER_OVF_EN.
module chunked_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic           clk,
   input  logic           rst,
   chunked_adder_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
   logic [CHUNK-1:0] a_c, b_c;
   logic [CHUNK:0]   csum;
   logic             last;
   logic             accept;

   assign a_c    = a_q[int'(cnt_q)*CHUNK +: CHUNK];
   assign b_c    = b_q[int'(cnt_q)*CHUNK +: CHUNK];
   assign csum   = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
   assign last   = (cnt_q == CW'(NCHUNK - 1));
   assign accept = (state_q == IDLE) && bus.start;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // Subtraction is folded into the operands: a + ~b + ~borrow.
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.cin ^ bus.sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[int'(cnt_q)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            carry_d = csum[CHUNK];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
               state_d = IDLE;
               cout_d  = csum[CHUNK];
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

`ifdef CHUNKED_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   logic c_msb;

   // Carry into the top bit recovered from the sum bit and its two operand bits.
   assign c_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ csum[CHUNK-1];

   always_comb begin
      ovf_d = ovf_q;
      if (accept)
         ovf_d = 1'b0;
      else if (state_q == RUN && last)
         ovf_d = c_msb ^ csum[CHUNK];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule
